aes_sbox_word_sched: RTL and testbench
======================================

# aes_sbox_word_sched

Sequencer and arbiter that shares one external byte-wide AES/AES⁻¹ S-box datapath between two 32-bit SubWord requesters: the core AES instruction unit (port 0) and the key-schedule unit (port 1). It accepts a word plus direction from the granted requester and feeds its four bytes through the shared S-box, one byte per cycle. It assembles the substituted word and returns it with the requester ID over a valid/ready response handshake. It sits between the requesters and the top/middle/bottom S-box layers, which remain purely combinational.

## Interface
Parameters:
- ROUND_ROBIN, 1, 1 = round-robin arbitration between ports; 0 = fixed priority, port 0 wins.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; drops the in-flight word and any held response.
- req0_valid / req1_valid  in  1  request valid for port 0 / port 1.
- req0_ready / req1_ready  out  1  request accepted this cycle when the matching valid is also 1.
- req0_data / req1_data  in  32  word to substitute.
- req0_inv / req1_inv  in  1  0 = forward S-box, 1 = inverse S-box.
- sbox_in  out  8  byte presented to the shared S-box.
- sbox_inv  out  1  direction select to the shared S-box.
- sbox_out  in  8  combinational S-box result for sbox_in.
- rsp_valid  out  1  result word available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  32  substituted word.
- rsp_id  out  1  requester that owns rsp_data.

## Operation
- FSM states:
  - IDLE: accepts one request. Goes to RUN on acceptance.
  - RUN: a 2-bit byte counter cnt steps 0→3. Goes to DONE after cnt = 3.
  - DONE: holds rsp_valid. Goes to IDLE when rsp_valid & rsp_ready.
- Ready generation:
  - reqN_ready = (state==IDLE) & !flush & grant==N & reqN_valid.
  - Both readies are 0 in RUN and DONE.
  - The granted requester's ready may depend combinationally on its own valid.
- Arbitration (ROUND_ROBIN=1):
  - A single valid request wins.
  - If both are valid, the port not granted last wins.
  - last_grant resets to 1, so port 0 wins the first tie.
  - last_grant updates only on acceptance.
- Arbitration (ROUND_ROBIN=0): port 0 always wins a tie.
- On acceptance, register:
  - the word into an input buffer,
  - inv into a direction register,
  - the granted ID.
- Byte order: byte k = word[8k+7:8k], processed LSB first.
- In RUN:
  - sbox_in = buffered byte cnt; sbox_inv = registered direction.
  - sbox_out is captured into result byte cnt at the end of the same cycle.
- Outside RUN, sbox_in = 0 and sbox_inv = 0, so the shared S-box does not toggle.
- rsp_data and rsp_id are stable for the whole DONE period.
- Request inputs are ignored outside IDLE; a requester holds its valid until it sees ready.
- flush in any state: next state IDLE, cnt = 0, rsp_valid = 0; no request is accepted in the flush cycle.
- flush and rsp_ready asserted in the same cycle: flush wins. The response is treated as dropped, not delivered.

## Timing
- Reset values:
  - state IDLE, cnt 0, last_grant 1.
  - rsp_valid 0, rsp_data 0x00000000, rsp_id 0.
  - sbox_in 0x00, sbox_inv 0.
- Request accept in cycle T (valid & ready):
  - bytes 0..3 go to the S-box in cycles T+1..T+4;
  - rsp_valid = 1 from cycle T+5.
- Accept-to-response latency: 5 cycles.
- Response handshake in cycle R:
  - IDLE in R+1;
  - the next accept can occur in R+1.
- Throughput with rsp_ready tied 1: one word per 6 cycles.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded.

## Test plan
- Single forward word: port 0 sends 0x53020100 with inv = 0.
  - sbox_in sequence 00, 01, 02, 53 in T+1..T+4.
  - rsp_data = 0xED777C63, rsp_id = 0, rsp_valid at T+5.
- Single inverse word: port 1 sends 0xED777C63 with inv = 1.
  - rsp_data = 0x53020100, rsp_id = 1, sbox_inv = 1 in all four RUN cycles.
- Contention (ROUND_ROBIN=1): both ports hold valid for 3 words each.
  - Grant order 0, 1, 0, 1, 0, 1.
  - With ROUND_ROBIN=0: all port 0 words complete before any port 1 word.
- Response backpressure: rsp_ready = 0 for 10 cycles after rsp_valid.
  - rsp_data and rsp_id stay stable; both readies stay 0.
  - The next accept happens the cycle after rsp_ready rises.
- Flush at cnt = 2: state returns to IDLE, rsp_valid is never asserted, and a new word 0x00000000 then returns 0x63636363.
- Async reset mid-RUN: all outputs reach reset values without a clock edge. After reset is released, port 0 wins the first tie.

Source files
------------

// File: rtl/aes_sbox_word_sched_if.sv
// rtl/aes_sbox_word_sched_if.sv - request, response and shared S-box signal bundle
//
// Purpose: groups the two SubWord request ports, the result response
//   port and the byte-wide shared S-box connection of aes_sbox_word_sched.
// Signals:
//   req0_* / req1_*  : valid/ready request, 32-bit word, direction (1 = inverse)
//   rsp_*            : valid/ready response, substituted word, owner ID
//   sbox_in/sbox_inv : byte and direction presented to the shared S-box
//   sbox_out         : combinational S-box result for sbox_in
// Modports: slave = the scheduler, master = requesters/consumer/S-box side.

interface aes_sbox_word_sched_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_data;
  logic        req0_inv;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_data;
  logic        req1_inv;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id;
  logic [7:0]  sbox_in;
  logic        sbox_inv;
  logic [7:0]  sbox_out;

  modport slave (
    input  req0_valid, req0_data, req0_inv,
    input  req1_valid, req1_data, req1_inv,
    input  rsp_ready, sbox_out,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id,
    output sbox_in, sbox_inv
  );

  modport master (
    output req0_valid, req0_data, req0_inv,
    output req1_valid, req1_data, req1_inv,
    output rsp_ready, sbox_out,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id,
    input  sbox_in, sbox_inv
  );
endinterface

// File: rtl/aes_sbox_word_sched.sv
// rtl/aes_sbox_word_sched.sv - arbiter/sequencer sharing one byte S-box between two SubWord requesters
//
// Purpose: accepts a 32-bit word and direction from port 0 (AES core) or
//   port 1 (key schedule), streams its bytes LSB first through the shared
//   S-box one per cycle, and returns the substituted word with its owner ID.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   flush : synchronous abort of the in-flight word and any held response
//   bus   : aes_sbox_word_sched_if.slave (requests, response, S-box link)
// Parameter ROUND_ROBIN: 1 = alternate on ties, 0 = port 0 always wins ties.

module aes_sbox_word_sched #(
  parameter int ROUND_ROBIN = 1
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  flush,
  aes_sbox_word_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic        r_last_grant;
  logic [31:0] r_buf;
  logic [31:0] r_res;
  logic        r_inv;
  logic        r_id;

  logic        w_grant;
  logic        w_rdy0;
  logic        w_rdy1;
  logic        w_accept;

  // Grant is only meaningful when at least one port is valid; a lone
  // valid always wins, ties go to the port not served last (or port 0).
  always_comb begin
    w_grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant = (ROUND_ROBIN != 0) ? ~r_last_grant : 1'b0;
    end else if (bus.req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_rdy0   = (r_state == S_IDLE) && !flush && !w_grant && bus.req0_valid;
  assign w_rdy1   = (r_state == S_IDLE) && !flush &&  w_grant && bus.req1_valid;
  assign w_accept = w_rdy0 || w_rdy1;

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.rsp_valid  = (r_state == S_DONE);
  assign bus.rsp_data   = r_res;
  assign bus.rsp_id     = r_id;

  // Next state plus the S-box drive; the S-box inputs are parked at zero
  // outside RUN so the shared combinational layers stay quiet.
  always_comb begin
    w_state_nxt  = r_state;
    bus.sbox_in  = 8'h00;
    bus.sbox_inv = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        bus.sbox_in  = r_buf[{r_cnt, 3'b000} +: 8];
        bus.sbox_inv = r_inv;
        if (r_cnt == 2'd3) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // flush overrides everything, including a same-cycle response handshake
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 2'd0;
      r_last_grant <= 1'b1;
      r_buf        <= 32'h0000_0000;
      r_res        <= 32'h0000_0000;
      r_inv        <= 1'b0;
      r_id         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      // counter wraps 3 -> 0 naturally as RUN hands over to DONE
      if (flush || (r_state != S_RUN)) begin
        r_cnt <= 2'd0;
      end else begin
        r_cnt <= r_cnt + 2'd1;
      end

      if (w_accept) begin
        r_buf        <= w_grant ? bus.req1_data : bus.req0_data;
        r_inv        <= w_grant ? bus.req1_inv  : bus.req0_inv;
        r_id         <= w_grant;
        r_last_grant <= w_grant;
      end

      if ((r_state == S_RUN) && !flush) begin
        r_res[{r_cnt, 3'b000} +: 8] <= bus.sbox_out;
      end
    end
  end

endmodule

// File: tb/tb_aes_sbox_word_sched.sv
// tb/tb_aes_sbox_word_sched.sv - randomized self-checking bench for aes_sbox_word_sched

module tb_aes_sbox_word_sched;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  aes_sbox_word_sched_if bus ();
  aes_sbox_word_sched_if bus_fp ();

  aes_sbox_word_sched #(.ROUND_ROBIN(1)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  aes_sbox_word_sched #(.ROUND_ROBIN(0)) dut_fp (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus_fp.slave)
  );

  always #5 clk = ~clk;

  // GF(2^8) arithmetic over x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_rev(input logic [7:0] s);
    return ginv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] sbox_env(input logic [7:0] x, input logic inv);
    return inv ? sbox_rev(x) : sbox_fwd(x);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w, input logic inv);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = sbox_env(w[8*k +: 8], inv);
    return r;
  endfunction

  assign bus.sbox_out    = sbox_env(bus.sbox_in, bus.sbox_inv);
  assign bus_fp.sbox_out = sbox_env(bus_fp.sbox_in, bus_fp.sbox_inv);

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // pending requests per port and the reference model of the scheduler
  logic [31:0] q0_data[$];
  logic        q0_inv[$];
  logic [31:0] q1_data[$];
  logic        q1_inv[$];
  int          grant_log[$];
  bit          m_busy;
  bit          m_last;
  int          m_acc;
  logic [31:0] m_word;
  logic [31:0] m_exp;
  bit          m_inv;
  bit          m_id;
  logic [31:0] last_rsp;
  logic        last_id;

  task automatic push(input int port, input logic [31:0] d, input logic inv);
    if (port == 0) begin
      q0_data.push_back(d);
      q0_inv.push_back(inv);
    end else begin
      q1_data.push_back(d);
      q1_inv.push_back(inv);
    end
  endtask

  // bp_mode: 0 rsp_ready=1, 1 random, 2 hold 0 for 10 cycles of DONE.
  // flush_k / rst_k: cycles after accept at which to flush / async reset.
  task automatic run(input int max_cyc, input int bp_mode, input int flush_k, input int rst_k);
    int cyc, k, hold;
    bit v0, v1, win, e0, e1, fl, rr, flushed, did_rst;
    logic [7:0] exp_sb;
    cyc = 0; hold = 0; flushed = 0; did_rst = 0;
    while ((q0_data.size() > 0 || q1_data.size() > 0 || m_busy) && cyc < max_cyc) begin
      @(negedge clk);
      reset = 1'b0;
      cyc++;
      k  = cyc - m_acc;
      v0 = (q0_data.size() > 0);
      v1 = (q1_data.size() > 0);
      bus.req0_valid = v0;
      bus.req0_data  = v0 ? q0_data[0] : $urandom();
      bus.req0_inv   = v0 ? q0_inv[0]  : 1'b0;
      bus.req1_valid = v1;
      bus.req1_data  = v1 ? q1_data[0] : $urandom();
      bus.req1_inv   = v1 ? q1_inv[0]  : 1'b0;
      fl = m_busy && !flushed && (flush_k > 0) && (k == flush_k);
      flush = fl;
      rr = 1'b1;
      if (bp_mode == 1) rr = 1'($urandom_range(0, 1));
      if (bp_mode == 2 && m_busy && k >= 5 && hold < 10) begin
        rr = 1'b0;
        hold++;
      end
      bus.rsp_ready = rr;
      #1;
      win = (v0 && v1) ? !m_last : v1;
      e0 = !m_busy && !fl && v0 && !win;
      e1 = !m_busy && !fl && v1 && win;
      check("req0_ready", bus.req0_ready, e0);
      check("req1_ready", bus.req1_ready, e1);
      check("rsp_valid", bus.rsp_valid, m_busy && k >= 5);
      exp_sb = 8'h00;
      if (m_busy && k >= 1 && k <= 4) exp_sb = m_word[8*(k-1) +: 8];
      check("sbox_in", bus.sbox_in, exp_sb);
      check("sbox_inv", bus.sbox_inv, m_busy && k >= 1 && k <= 4 && m_inv);
      if (m_busy && k >= 5) begin
        check("rsp_data", bus.rsp_data, m_exp);
        check("rsp_id", bus.rsp_id, m_id);
      end
      if (rst_k > 0 && m_busy && !did_rst && k == rst_k) begin
        reset = 1'b1;
        #1;
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_sbox_in", bus.sbox_in, 0);
        check("rst_sbox_inv", bus.sbox_inv, 0);
        m_busy = 0;
        m_last = 1;
        did_rst = 1;
      end else if (e0 || e1) begin
        m_busy = 1;
        m_acc  = cyc;
        m_id   = e1;
        m_last = e1;
        grant_log.push_back(int'(e1));
        if (e1) begin
          m_word = q1_data.pop_front();
          m_inv  = q1_inv.pop_front();
        end else begin
          m_word = q0_data.pop_front();
          m_inv  = q0_inv.pop_front();
        end
        m_exp = sub_word(m_word, m_inv);
      end else if (fl) begin
        m_busy  = 0;
        flushed = 1;
      end else if (m_busy && k >= 5 && rr) begin
        last_rsp = bus.rsp_data;
        last_id  = bus.rsp_id;
        m_busy   = 0;
      end
    end
    check("drain", q0_data.size() + q1_data.size() + int'(m_busy), 0);
    @(negedge clk);
    flush = 1'b0;
    reset = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic run_fp();
    int n0, n1;
    logic [5:0] ord;
    int fp_log[$];
    n0 = 0; n1 = 0;
    for (int c = 0; c < 100 && fp_log.size() < 6; c++) begin
      @(negedge clk);
      bus_fp.req0_valid = (n0 < 3);
      bus_fp.req0_data  = $urandom();
      bus_fp.req0_inv   = 1'($urandom_range(0, 1));
      bus_fp.req1_valid = (n1 < 3);
      bus_fp.req1_data  = $urandom();
      bus_fp.req1_inv   = 1'($urandom_range(0, 1));
      bus_fp.rsp_ready  = 1'b1;
      #1;
      if (bus_fp.req0_ready) begin fp_log.push_back(0); n0++; end
      if (bus_fp.req1_ready) begin fp_log.push_back(1); n1++; end
    end
    @(negedge clk);
    bus_fp.req0_valid = 1'b0;
    bus_fp.req1_valid = 1'b0;
    ord = 6'h3f;
    for (int i = 0; i < 6 && i < fp_log.size(); i++) ord[i] = fp_log[i][0];
    check("fp_grant_order", ord, 6'b111000);
  endtask

  initial begin
    logic [5:0] ord;
    reset = 1'b1;
    flush = 1'b0;
    bus.req0_valid = 0; bus.req0_data = 0; bus.req0_inv = 0;
    bus.req1_valid = 0; bus.req1_data = 0; bus.req1_inv = 0;
    bus.rsp_ready  = 0;
    bus_fp.req0_valid = 0; bus_fp.req0_data = 0; bus_fp.req0_inv = 0;
    bus_fp.req1_valid = 0; bus_fp.req1_data = 0; bus_fp.req1_inv = 0;
    bus_fp.rsp_ready  = 0;
    m_busy = 0; m_last = 1; m_acc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_data", bus.rsp_data, 0);
    check("reset_rsp_id", bus.rsp_id, 0);
    check("reset_sbox_in", bus.sbox_in, 0);
    check("reset_sbox_inv", bus.sbox_inv, 0);
    check("reset_req0_ready", bus.req0_ready, 0);

    push(0, 32'h53020100, 1'b0);
    run(50, 0, 0, 0);
    check("fwd_word", last_rsp, 32'hED777C63);
    check("fwd_id", last_id, 0);

    push(1, 32'hED777C63, 1'b1);
    run(50, 0, 0, 0);
    check("inv_word", last_rsp, 32'h53020100);
    check("inv_id", last_id, 1);

    grant_log.delete();
    for (int i = 0; i < 3; i++) begin
      push(0, $urandom(), 1'($urandom_range(0, 1)));
      push(1, $urandom(), 1'($urandom_range(0, 1)));
    end
    run(200, 0, 0, 0);
    ord = 6'h3f;
    for (int i = 0; i < 6 && i < grant_log.size(); i++) ord[i] = grant_log[i][0];
    check("rr_grant_order", ord, 6'b101010);

    push(0, $urandom(), 1'b0);
    push(1, $urandom(), 1'b1);
    run(200, 2, 0, 0);

    push(0, $urandom(), 1'($urandom_range(0, 1)));
    run(50, 0, 3, 0);
    push(0, 32'h00000000, 1'b0);
    run(50, 0, 0, 0);
    check("post_flush_word", last_rsp, 32'h63636363);

    for (int i = 0; i < 40; i++) push(int'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)));
    run(2000, 1, 0, 0);

    run_fp();

    push(0, $urandom(), 1'b0);
    run(50, 0, 0, 2);
    grant_log.delete();
    push(0, $urandom(), 1'($urandom_range(0, 1)));
    push(1, $urandom(), 1'($urandom_range(0, 1)));
    run(100, 0, 0, 0);
    check("post_reset_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
